// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller: FSM state encodings
// and the default memory address width.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned MEM_ADDR = 32;

  localparam logic [1:0] CTRL_ST_IDLE = 2'd0;
  localparam logic [1:0] CTRL_ST_RISK = 2'd1;
  localparam logic [1:0] CTRL_ST_HOLD = 2'd2;

endpackage

// File: rtl/ctrl_perf_cnt.sv
// Saturating event counter used for the optional controller performance statistics.
module ctrl_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: system hold priority, multi-cycle data-hazard stall, irq/EX redirects
// with a pending-jump register. Optional perf counters under `CTRL_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = MEM_ADDR,
  parameter int unsigned HOLD_SRC  = 4,
  parameter int unsigned STALL_CYC = 1
`ifdef CTRL_PERF_CNT_EN
  , parameter int unsigned CNT_W   = 32
`endif
) (
  input  logic                clk_100MHz,
  input  logic                arst_n,
  input  logic [HOLD_SRC-1:0] hold_req_i,
  input  logic                ex_hold_risk_i,
  input  logic                ex_jump_i,
  input  logic [ADDR_W-1:0]   ex_jump_addr_i,
  input  logic                irq_jump_i,
  input  logic [ADDR_W-1:0]   irq_jump_addr_i,
  output logic                hold_ena_o,
  output logic [HOLD_SRC-1:0] hold_src_o,
  output logic                jump_ena_o,
  output logic [ADDR_W-1:0]   jump_addr_o,
  output logic                pc_hold_o,
  output logic                pc_id_hold_o,
  output logic                pc_id_clr_o,
  output logic                id_ex_clr_o,
  output logic                busy_o
`ifdef CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
`endif
);

  localparam int unsigned CNT_BITS = $clog2(STALL_CYC + 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;

  logic              hold_any;
  logic              redir_req;
  logic [ADDR_W-1:0] redir_addr;
  logic              risk_active;
  logic              src_found;

  assign hold_any   = |hold_req_i;
  assign hold_ena_o = hold_any;

  always_comb begin
    hold_src_o = '0;
    src_found  = 1'b0;
    for (int unsigned i = 0; i < HOLD_SRC; i++) begin
      if (hold_req_i[i] && !src_found) begin
        hold_src_o[i] = 1'b1;
        src_found     = 1'b1;
      end
    end
  end

  assign redir_req  = irq_jump_i | pend_vld_q | ex_jump_i;
  assign redir_addr = irq_jump_i ? irq_jump_addr_i :
                      pend_vld_q ? pend_addr_q     : ex_jump_addr_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    jump_ena_o  = 1'b0;
    risk_active = 1'b0;
    if (!hold_any) begin
      if (redir_req) begin
        // Any issued redirect also retires the pending slot and aborts a stall.
        jump_ena_o = 1'b1;
        pend_vld_d = 1'b0;
        cnt_d      = '0;
        state_d    = CTRL_ST_IDLE;
      end else begin
        case (state_q)
          CTRL_ST_RISK: begin
            risk_active = 1'b1;
            cnt_d       = cnt_q - CNT_BITS'(1);
            if (cnt_d == '0) state_d = CTRL_ST_IDLE;
          end
          CTRL_ST_HOLD: state_d = CTRL_ST_IDLE;
          default: begin
            if (ex_hold_risk_i) begin
              risk_active = 1'b1;
              if (STALL_CYC > 1) begin
                state_d = CTRL_ST_RISK;
                cnt_d   = CNT_BITS'(STALL_CYC - 1);
              end
            end
          end
        endcase
      end
    end else if (irq_jump_i) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = irq_jump_addr_i;
      state_d     = CTRL_ST_HOLD;
    end else if (ex_jump_i && !pend_vld_q) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = ex_jump_addr_i;
      state_d     = CTRL_ST_HOLD;
    end
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= CTRL_ST_IDLE;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign jump_addr_o  = jump_ena_o ? redir_addr : '0;
  assign pc_hold_o    = hold_any | risk_active;
  assign pc_id_hold_o = hold_any | risk_active;
  assign pc_id_clr_o  = jump_ena_o;
  assign id_ex_clr_o  = jump_ena_o | risk_active;
  assign busy_o       = (state_q != CTRL_ST_IDLE) | pend_vld_q;

`ifdef CTRL_PERF_CNT_EN
  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk_100MHz),
    .rst_n (arst_n),
    .inc   (pc_hold_o),
    .cnt   (stall_cnt_o)
  );

  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk_100MHz),
    .rst_n (arst_n),
    .inc   (jump_ena_o),
    .cnt   (flush_cnt_o)
  );
`endif

endmodule
